// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle RV32I control unit sequencing datapath enables, mux selects and ALU op.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
        EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;

    state_t cur, nxt;
    logic [13:0] ctl;
    logic pc_update, branch, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, src_a, src_b, alu_op;

    // {pc_update, branch, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, alu_op}
    function automatic logic [13:0] moore(state_t s);
        case (s)
            FETCH:    moore = 14'b1_0_0_0_1_0_10_00_10_00;
            DECODE:   moore = 14'b0_0_0_0_0_0_00_01_01_00;
            MEMADR:   moore = 14'b0_0_0_0_0_0_00_10_01_00;
            MEMREAD:  moore = 14'b0_0_1_0_0_0_00_00_00_00;
            MEMWB:    moore = 14'b0_0_0_0_0_1_01_00_00_00;
            MEMWRITE: moore = 14'b0_0_1_1_0_0_00_00_00_00;
            EXECR:    moore = 14'b0_0_0_0_0_0_00_10_00_10;
            EXECI:    moore = 14'b0_0_0_0_0_0_00_10_01_10;
            ALUWB:    moore = 14'b0_0_0_0_0_1_00_00_00_00;
            BEQ:      moore = 14'b0_1_0_0_0_0_00_10_00_01;
            JAL:      moore = 14'b1_0_0_0_0_0_00_01_10_00;
            default:  moore = 14'b0;
        endcase
    endfunction

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                           op == OP_R   ? EXECR :
                           op == OP_I   ? EXECI :
                           op == OP_JAL ? JAL   :
                           op == OP_BEQ ? BEQ   : FETCH;
            MEMADR:  nxt = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD: nxt = MEMWB;
            EXECR, EXECI, JAL: nxt = ALUWB;
            default: nxt = FETCH;
        endcase
    end

    // Control word is registered alongside the state so Moore outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= state_t'(RESET_STATE);
            ctl <= moore(state_t'(RESET_STATE));
        end else begin
            cur <= nxt;
            ctl <= moore(nxt);
        end
    end

    assign {pc_update, branch, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, alu_op} = ctl;

    assign PCWrite    = rst_n & (pc_update | (branch & Zero));
    assign IRWrite    = rst_n & ir_write;
    assign MemWrite   = rst_n & mem_write;
    assign RegWrite   = rst_n & reg_write;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = src_a;
    assign ALUSrcB    = src_b;
    assign state      = cur;
    assign illegal_op = (cur == DECODE) && !(op == OP_LW || op == OP_SW || op == OP_R ||
                                             op == OP_I || op == OP_JAL || op == OP_BEQ);

    always_comb begin
        ImmSrc = op == OP_SW  ? 2'b01 :
                 op == OP_BEQ ? 2'b10 :
                 op == OP_JAL ? 2'b11 : 2'b00;
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: case (funct3)
                3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                3'b010:  ALUControl = 3'b101;
                3'b110:  ALUControl = 3'b011;
                3'b111:  ALUControl = 3'b010;
                default: ALUControl = 3'b000;
            endcase
            default: ALUControl = 3'b000;
        endcase
    end
endmodule
